multi_sqr_object: RTL and testbench
===================================

MULTI_SQR_OBJECT -- requirements
Module: multi_sqr_object

Interface
REQ-001 SHALL have parameter NUM_OBJECTS, default 4, number of rectangles tested per pixel (range 2..16).
REQ-002 SHALL have parameter OBJECT_WIDTH_X, default 32, rectangle width in screen pixels, common to all objects.
REQ-003 SHALL have parameter OBJECT_HEIGHT_Y, default 32, rectangle height in screen pixels, common to all objects.
REQ-004 SHALL have parameter SCALE_SHIFT, default 0, right-shift applied to offsets, giving 2^SCALE_SHIFT bitmap magnification.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports pixelX and pixelY, input, 11 signed each, current VGA pixel.
REQ-008 SHALL have port startOfFrame, input, 1, one-cycle pulse marking frame start.
REQ-009 SHALL have ports topLeftX and topLeftY, input, NUM_OBJECTS*11 each, packed signed positions (object i at bits [11i+10:11i]).
REQ-010 SHALL have port objEnable, input, NUM_OBJECTS, per-object enable.
REQ-011 SHALL have ports offsetX and offsetY, output, 11 each, scaled offset inside the selected object.
REQ-012 SHALL have port insideRectangle, output, 1, pixel inside at least one enabled object.
REQ-013 SHALL have port hitIndex, output, $clog2(NUM_OBJECTS), index of the selected object.
REQ-014 SHALL have port hitVector, output, NUM_OBJECTS, per-object inside flags.
REQ-015 SHALL have port collision, output, 1, sticky overlap flag for the current frame.

Function
REQ-016 SHALL hold shadow copies of topLeftX, topLeftY and objEnable, loaded only on cycles where startOfFrame=1, so positions cannot change mid-frame.
REQ-017 SHALL perform hit tests against shadow values; on a startOfFrame cycle the test uses the pre-load shadow values.
REQ-018 SHALL flag object i as hit when its shadow enable=1 and topLeftX_i <= pixelX < topLeftX_i+OBJECT_WIDTH_X and topLeftY_i <= pixelY < topLeftY_i+OBJECT_HEIGHT_Y, using signed arithmetic at least 12 bits wide (no wrap for negative or near-2047 positions).
REQ-019 SHALL select the lowest-indexed hit object (index 0 highest priority, drawn on top).
REQ-020 SHALL register all outputs with latency exactly 1 clock from pixelX/pixelY.
REQ-021 SHALL drive offsetX=(pixelX-topLeftX_sel)>>SCALE_SHIFT and offsetY=(pixelY-topLeftY_sel)>>SCALE_SHIFT (logical shift, result always non-negative).
REQ-022 SHALL, with no hit, drive insideRectangle=0, offsetX=0, offsetY=0, hitIndex=0, hitVector=0.
REQ-023 SHALL drive hitVector bit i with the raw hit flag of object i, independent of priority.

Reset
REQ-024 SHALL, while resetN=0, asynchronously clear all outputs to 0, all shadow positions to 0 and all shadow enables to 0.
REQ-025 SHALL report no hits after reset until the first startOfFrame loads the shadow registers.
REQ-026 SHALL, on reset mid-frame, drop any in-progress hit and clear collision immediately.

Configuration
REQ-027 SHALL compile collision logic only when macro MULTI_SQR_COLLISION_EN is defined.
REQ-028 SHALL, with MULTI_SQR_COLLISION_EN defined, set collision one cycle after any cycle in which two or more hitVector bits are set, and hold it until the next startOfFrame.
REQ-029 SHALL, with MULTI_SQR_COLLISION_EN defined, let clear win when startOfFrame and a new overlap occur in the same cycle (collision=0 next cycle).
REQ-030 SHALL, without MULTI_SQR_COLLISION_EN, tie collision to constant 0 with no collision flops.

Verification
REQ-031 SHALL cover: reset, then pixel (10,10), object0 at (0,0) enabled but no startOfFrame -> insideRectangle=0.
REQ-032 SHALL cover: after startOfFrame load of object0 at (100,50), pixel (131,81) -> one cycle later insideRectangle=1, hitIndex=0, offsets (31,31); pixel (132,50) -> insideRectangle=0.
REQ-033 SHALL cover: objects 1 and 2 both at (200,200), pixel (205,210) -> hitVector=4'b0110, hitIndex=1, offsets (5,10); collision=1 next cycle with MULTI_SQR_COLLISION_EN defined and remains 1 until startOfFrame, else 0.
REQ-034 SHALL cover: object3 at (-10,-5), pixel (0,0) -> hit, offsets (10,5); pixel (21,0) -> hit; pixel (22,0) -> no hit.
REQ-035 SHALL cover: SCALE_SHIFT=2, object0 at (40,40), pixel (47,53) -> offsets (1,3).
REQ-036 SHALL cover: topLeftX input changed mid-frame without startOfFrame -> hits track old position until the next startOfFrame pulse.

Source files
------------

// File: rtl/multi_sqr_object.sv
// multi_sqr_object: tests the current VGA pixel against NUM_OBJECTS equal-sized
// rectangles whose positions are latched once per frame. Reports the
// highest-priority (lowest-index) hit with its scaled in-object offset, plus
// the raw per-object hit flags.
// Optional feature: define MULTI_SQR_COLLISION_EN to build the sticky
// per-frame overlap flag; otherwise collision is tied low.
module multi_sqr_object #(
   parameter int NUM_OBJECTS     = 4,
   parameter int OBJECT_WIDTH_X  = 32,
   parameter int OBJECT_HEIGHT_Y = 32,
   parameter int SCALE_SHIFT     = 0
) (
   input  logic                              clk,
   input  logic                              resetN,
   input  logic signed [10:0]                pixelX,
   input  logic signed [10:0]                pixelY,
   input  logic                              startOfFrame,
   input  logic [NUM_OBJECTS*11-1:0]         topLeftX,
   input  logic [NUM_OBJECTS*11-1:0]         topLeftY,
   input  logic [NUM_OBJECTS-1:0]            objEnable,
   output logic [10:0]                       offsetX,
   output logic [10:0]                       offsetY,
   output logic                              insideRectangle,
   output logic [$clog2(NUM_OBJECTS)-1:0]    hitIndex,
   output logic [NUM_OBJECTS-1:0]            hitVector,
   output logic                              collision
);

   // 13-bit signed arithmetic: pixel minus position never wraps
   localparam int unsigned AW    = 13;
   localparam int unsigned IDX_W = $clog2(NUM_OBJECTS);
   localparam logic signed [AW-1:0] W_S = AW'(OBJECT_WIDTH_X);
   localparam logic signed [AW-1:0] H_S = AW'(OBJECT_HEIGHT_Y);

   logic signed [10:0]     sh_x [NUM_OBJECTS];
   logic signed [10:0]     sh_y [NUM_OBJECTS];
   logic [NUM_OBJECTS-1:0] sh_en;

   logic signed [AW-1:0]   px;
   logic signed [AW-1:0]   py;
   logic signed [AW-1:0]   rel_x [NUM_OBJECTS];
   logic signed [AW-1:0]   rel_y [NUM_OBJECTS];
   logic [NUM_OBJECTS-1:0] hit_c;
   logic [IDX_W-1:0]       sel_idx_c;
   logic signed [AW-1:0]   sel_dx_c;
   logic signed [AW-1:0]   sel_dy_c;
   logic [10:0]            off_x_c;
   logic [10:0]            off_y_c;

   assign px = AW'(pixelX);
   assign py = AW'(pixelY);

   // Shadow positions/enables: only updated on the frame-start pulse
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_OBJECTS; i++) begin
            sh_x[i] <= '0;
            sh_y[i] <= '0;
         end
         sh_en <= '0;
      end else if (startOfFrame) begin
         for (int i = 0; i < NUM_OBJECTS; i++) begin
            sh_x[i] <= topLeftX[11*i +: 11];
            sh_y[i] <= topLeftY[11*i +: 11];
         end
         sh_en <= objEnable;
      end
   end

   // Per-object relative position and inside test (0 <= rel < size)
   for (genvar g = 0; g < NUM_OBJECTS; g++) begin : g_obj
      assign rel_x[g] = px - AW'(sh_x[g]);
      assign rel_y[g] = py - AW'(sh_y[g]);
      assign hit_c[g] = sh_en[g] & ~rel_x[g][AW-1] & (rel_x[g] < W_S)
                                 & ~rel_y[g][AW-1] & (rel_y[g] < H_S);
   end

   // Priority select: scan high to low so the lowest hit index wins
   always_comb begin
      sel_idx_c = '0;
      sel_dx_c  = '0;
      sel_dy_c  = '0;
      for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
         if (hit_c[i]) begin
            sel_idx_c = IDX_W'(i);
            sel_dx_c  = rel_x[i];
            sel_dy_c  = rel_y[i];
         end
      end
   end

   // Offsets are non-negative whenever selected, zero otherwise
   assign off_x_c = 11'($unsigned(sel_dx_c) >> SCALE_SHIFT);
   assign off_y_c = 11'($unsigned(sel_dy_c) >> SCALE_SHIFT);

   // Output register stage: one clock after the pixel coordinates
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         offsetX         <= '0;
         offsetY         <= '0;
         insideRectangle <= 1'b0;
         hitIndex        <= '0;
         hitVector       <= '0;
      end else begin
         offsetX         <= off_x_c;
         offsetY         <= off_y_c;
         insideRectangle <= |hit_c;
         hitIndex        <= sel_idx_c;
         hitVector       <= hit_c;
      end
   end

`ifdef MULTI_SQR_COLLISION_EN
   // Sticky overlap flag: set after a multi-bit hitVector, frame start clears first
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         collision <= 1'b0;
      end else if (startOfFrame) begin
         collision <= 1'b0;
      end else if (|(hitVector & (hitVector - NUM_OBJECTS'(1)))) begin
         collision <= 1'b1;
      end
   end
`else
   assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sqr_object.sv
// Scoreboard bench for multi_sqr_object: two instances (scale 1x and 4x)
// share stimulus; each stimulus cycle pushes the expected registered outputs
// and a monitor pops/compares one cycle later.
module tb_multi_sqr_object;

`ifdef MULTI_SQR_COLLISION_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               resetN;
   logic signed [10:0] pixelX, pixelY;
   logic               startOfFrame;
   logic [43:0]        topLeftX, topLeftY;
   logic [3:0]         objEnable;

   logic [10:0] a_ox, a_oy, b_ox, b_oy;
   logic        a_ins, b_ins, a_coll, b_coll;
   logic [1:0]  a_idx, b_idx;
   logic [3:0]  a_hv, b_hv;

   typedef struct {
      int         id;
      bit         sel;
      logic       ins;
      logic [10:0] ox;
      logic [10:0] oy;
      logic [1:0] idx;
      logic [3:0] hv;
      logic       coll;
   } exp_t;

   exp_t exp_q[$];
   bit   issue = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   multi_sqr_object #(.NUM_OBJECTS(4), .OBJECT_WIDTH_X(32), .OBJECT_HEIGHT_Y(32), .SCALE_SHIFT(0)) dut_a (
      .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame), .topLeftX(topLeftX), .topLeftY(topLeftY),
      .objEnable(objEnable), .offsetX(a_ox), .offsetY(a_oy),
      .insideRectangle(a_ins), .hitIndex(a_idx), .hitVector(a_hv), .collision(a_coll));

   multi_sqr_object #(.NUM_OBJECTS(4), .OBJECT_WIDTH_X(32), .OBJECT_HEIGHT_Y(32), .SCALE_SHIFT(2)) dut_b (
      .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame), .topLeftX(topLeftX), .topLeftY(topLeftY),
      .objEnable(objEnable), .offsetX(b_ox), .offsetY(b_oy),
      .insideRectangle(b_ins), .hitIndex(b_idx), .hitVector(b_hv), .collision(b_coll));

   task automatic set_obj(input int i, input int x, input int y);
      topLeftX[11*i +: 11] = 11'(x);
      topLeftY[11*i +: 11] = 11'(y);
   endtask

   // One stimulus cycle plus its expected response one clock later
   task automatic cyc(input int id, input bit rstn, input bit sel, input int x, input int y,
                      input bit sof, input bit ins, input int ox, input int oy, input int idx,
                      input logic [3:0] hv, input bit coll);
      exp_t e;
      @(negedge clk);
      resetN       = rstn;
      pixelX       = 11'(x);
      pixelY       = 11'(y);
      startOfFrame = sof;
      issue        = 1'b1;
      e.id   = id;
      e.sel  = sel;
      e.ins  = ins;
      e.ox   = 11'(ox);
      e.oy   = 11'(oy);
      e.idx  = 2'(idx);
      e.hv   = hv;
      e.coll = coll & COLL_EN;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs sampled 2 time units after the active edge
   initial begin
      exp_t e;
      logic [10:0] ox, oy;
      logic ins, coll;
      logic [1:0] idx;
      logic [3:0] hv;
      forever begin
         @(posedge clk);
         if (issue) begin
            #2;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL scoreboard: output cycle with empty expected queue");
            end else begin
               e = exp_q.pop_front();
               if (e.sel) begin
                  ins = b_ins; ox = b_ox; oy = b_oy; idx = b_idx; hv = b_hv; coll = b_coll;
               end else begin
                  ins = a_ins; ox = a_ox; oy = a_oy; idx = a_idx; hv = a_hv; coll = a_coll;
               end
               if (ins !== e.ins || ox !== e.ox || oy !== e.oy || idx !== e.idx ||
                   hv !== e.hv || coll !== e.coll) begin
                  n_bad++;
                  $display("FAIL step%0d dut%0d: got ins=%0b off=(%0d,%0d) idx=%0d hv=%b coll=%0b, want ins=%0b off=(%0d,%0d) idx=%0d hv=%b coll=%0b",
                           e.id, e.sel, ins, ox, oy, idx, hv, coll,
                           e.ins, e.ox, e.oy, e.idx, e.hv, e.coll);
               end
            end
         end
      end
   end

   initial begin
      resetN = 1'b0; pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
      topLeftX = '0; topLeftY = '0; objEnable = 4'b0001;

      // reset, then object0 enabled at (0,0) but never loaded
      cyc( 0, 0, 0,  10,  10, 0, 0,  0,  0, 0, 4'b0000, 0);
      cyc( 1, 1, 0,  10,  10, 0, 0,  0,  0, 0, 4'b0000, 0);
      // load object0 at (100,50); the loading cycle still sees old shadows
      set_obj(0, 100, 50);
      cyc( 2, 1, 0, 131,  81, 1, 0,  0,  0, 0, 4'b0000, 0);
      cyc( 3, 1, 0, 131,  81, 0, 1, 31, 31, 0, 4'b0001, 0);
      cyc( 4, 1, 1, 131,  81, 0, 1,  7,  7, 0, 4'b0001, 0);
      cyc( 5, 1, 0, 132,  50, 0, 0,  0,  0, 0, 4'b0000, 0);
      cyc( 6, 1, 0, 130,  49, 0, 0,  0,  0, 0, 4'b0000, 0);
      cyc( 7, 1, 0, 100,  50, 0, 1,  0,  0, 0, 4'b0001, 0);
      // move object0 mid-frame: hits follow old position until frame start
      set_obj(0, 500, 50);
      cyc( 8, 1, 0, 100,  50, 0, 1,  0,  0, 0, 4'b0001, 0);
      cyc( 9, 1, 0, 500,  50, 1, 0,  0,  0, 0, 4'b0000, 0);
      cyc(10, 1, 0, 500,  50, 0, 1,  0,  0, 0, 4'b0001, 0);
      cyc(11, 1, 0, 100,  50, 0, 0,  0,  0, 0, 4'b0000, 0);
      // overlapping objects 1,2 and negative-positioned object3
      set_obj(1, 200, 200); set_obj(2, 200, 200); set_obj(3, -10, -5);
      objEnable = 4'b1111;
      cyc(12, 1, 0,   0,   0, 1, 0,  0,  0, 0, 4'b0000, 0);
      cyc(13, 1, 0, 205, 210, 0, 1,  5, 10, 1, 4'b0110, 0);
      cyc(14, 1, 0,   0,   0, 0, 1, 10,  5, 3, 4'b1000, 1);
      cyc(15, 1, 0,  21,   0, 0, 1, 31,  5, 3, 4'b1000, 1);
      cyc(16, 1, 0,  22,   0, 0, 0,  0,  0, 0, 4'b0000, 1);
      cyc(17, 1, 0, 205, 210, 1, 1,  5, 10, 1, 4'b0110, 0);
      cyc(18, 1, 0,   0,   0, 0, 1, 10,  5, 3, 4'b1000, 1);
      cyc(19, 1, 0, 205, 210, 0, 1,  5, 10, 1, 4'b0110, 1);
      // frame start coincides with pending overlap: clear wins
      cyc(20, 1, 0,   0,   0, 1, 1, 10,  5, 3, 4'b1000, 0);
      cyc(21, 1, 0,  22,   0, 0, 0,  0,  0, 0, 4'b0000, 0);
      // scaled offsets on the 4x instance
      set_obj(0, 40, 40);
      cyc(22, 1, 0,  47,  53, 1, 0,  0,  0, 0, 4'b0000, 0);
      cyc(23, 1, 1,  47,  53, 0, 1,  1,  3, 0, 4'b0001, 0);
      cyc(24, 1, 0,  47,  53, 0, 1,  7, 13, 0, 4'b0001, 0);
      cyc(25, 1, 0, 205, 210, 0, 1,  5, 10, 1, 4'b0110, 0);
      cyc(26, 1, 0, 205, 210, 0, 1,  5, 10, 1, 4'b0110, 1);
      // mid-frame reset drops hits, collision and shadows
      cyc(27, 0, 0, 205, 210, 0, 0,  0,  0, 0, 4'b0000, 0);
      cyc(28, 1, 0, 205, 210, 0, 0,  0,  0, 0, 4'b0000, 0);
      cyc(29, 1, 1,   0,   0, 0, 0,  0,  0, 0, 4'b0000, 0);

      @(negedge clk);
      issue = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
